// File: rtl/sd_ckgen_pkg.sv
// Shared constants and state encoding for the SD-card clock generator.
package sd_ckgen_pkg;

  localparam logic [7:0] CKW_SPD0       = 8'h33;
  localparam logic [7:0] CKW_SPD0_90    = 8'h66;
  localparam logic [7:0] CKW_SPD1       = 8'h0f;
  localparam logic [7:0] CKW_SPD1_90    = 8'h3c;
  localparam logic [7:0] CKW_HI         = 8'hff;
  localparam logic [7:0] CKW_LO         = 8'h00;
  localparam logic [7:0] CKW_SPD2_90_HI = 8'hf0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_HI   = 2'd1,
    RUN_LO   = 2'd2,
    STOPPING = 2'd3
  } ck_state_t;

endpackage

// File: rtl/sd_ckgen_halfcnt.sv
// Half-period down-counter: loads on request, otherwise counts down and holds at zero.
module ckgen_halfcnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= 8'd0;
    else if (load)
      count <= load_val;
    else if (count != 8'd0)
      count <= count - 8'd1;
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/sd_ckgen.sv
// Programmable SD card clock generator: legalises the requested divider/phase and
// sequences card-clock samples plus rising/falling edge strobes from the system clock.
module sd_ckgen
  import sd_ckgen_pkg::*;
#(
  parameter bit OPT_SERDES = 1'b0,
  parameter bit OPT_DDR    = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [7:0] i_ckspd,
  input  logic       i_clk90,
  output logic       o_ckstb,
  output logic       o_hlfck,
  output logic [7:0] o_ckwide,
  output logic [7:0] o_ckspd,
  output logic       o_clk90
);

  ck_state_t  state;
  logic [7:0] spd_l, use_spd, cnt_val, rise_wide, fall_wide;
  logic       c90_l, use_c90, load_cfg, cnt_load, cnt_zero;
  logic       hi_done, lo_done, rise_now, fall_now, rise_both;

  always_comb begin
    spd_l = i_ckspd;
    if (i_ckspd == 8'd0 && !OPT_SERDES)
      spd_l = OPT_DDR ? 8'd1 : 8'd2;
    else if (i_ckspd == 8'd1 && !OPT_SERDES && !OPT_DDR)
      spd_l = 8'd2;
    c90_l = i_clk90;
    if ((spd_l <= 8'd1 && !OPT_SERDES) || (spd_l == 8'd2 && !OPT_SERDES && !OPT_DDR) ||
        spd_l >= 8'd3)
      c90_l = 1'b0;
  end

  // Next-cycle decisions in a falling-edge cycle already see the freshly loaded config.
  assign load_cfg = o_ckstb || (state == IDLE);
  assign use_spd  = load_cfg ? spd_l : o_ckspd;
  assign use_c90  = load_cfg ? c90_l : o_clk90;

  assign hi_done  = (o_ckspd <= 8'd2) || cnt_zero;
  assign lo_done  = (use_spd <= 8'd2) || (!o_ckstb && cnt_zero);
  assign fall_now = (state == RUN_HI || state == STOPPING) && hi_done;
  assign rise_now = i_en && (state == IDLE || (state == RUN_LO && lo_done));

  always_comb begin
    rise_both = (use_spd <= 8'd1);
    rise_wide = CKW_HI;
    if (use_spd == 8'd0)
      rise_wide = use_c90 ? CKW_SPD0_90 : CKW_SPD0;
    else if (use_spd == 8'd1)
      rise_wide = use_c90 ? CKW_SPD1_90 : CKW_SPD1;
    else if (use_spd == 8'd2 && use_c90)
      rise_wide = CKW_SPD2_90_HI;
    fall_wide = (state == RUN_HI && i_en && o_ckspd == 8'd2 && o_clk90) ? CKW_SPD1 : CKW_LO;
  end

  // The falling-edge cycle reloads one short so a new speed governs the whole low half.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = 8'd0;
    if (rise_now && use_spd >= 8'd3) begin
      cnt_load = 1'b1;
      cnt_val  = use_spd - 8'd2;
    end else if (fall_now && o_ckspd >= 8'd3) begin
      cnt_load = 1'b1;
      cnt_val  = o_ckspd - 8'd2;
    end else if (state == RUN_LO && o_ckstb && i_en && use_spd >= 8'd3) begin
      cnt_load = 1'b1;
      cnt_val  = use_spd - 8'd3;
    end
  end

  ckgen_halfcnt u_halfcnt (
    .clk      (i_clk),
    .rst      (i_reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      o_ckstb  <= 1'b0;
      o_hlfck  <= 1'b0;
      o_ckwide <= CKW_LO;
      o_ckspd  <= 8'hff;
      o_clk90  <= 1'b0;
    end else begin
      if (load_cfg) begin
        o_ckspd <= spd_l;
        o_clk90 <= c90_l;
      end
      o_ckstb  <= 1'b0;
      o_hlfck  <= 1'b0;
      o_ckwide <= CKW_LO;
      if (rise_now) begin
        state    <= rise_both ? RUN_LO : RUN_HI;
        o_hlfck  <= 1'b1;
        o_ckstb  <= rise_both;
        o_ckwide <= rise_wide;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          RUN_HI, STOPPING: begin
            if (hi_done) begin
              state    <= RUN_LO;
              o_ckstb  <= 1'b1;
              o_ckwide <= fall_wide;
            end else begin
              o_ckwide <= CKW_HI;
              if (!i_en) state <= STOPPING;
            end
          end
          RUN_LO: if (!i_en) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_ckgen.sv
// Directed bench for sd_ckgen: plain, SERDES and DDR builds driven from shared inputs.
module tb_sd_ckgen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clk90 = 1'b0;
  logic [7:0] ckspd = 8'd0;

  logic       b_stb, b_hlf, b_c90, s_stb, s_hlf, s_c90, d_stb, d_hlf, d_c90;
  logic [7:0] b_w, b_spd, s_w, s_spd, d_w, d_spd;

  int passed = 0;
  int total = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sd_ckgen u_base (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_ckspd(ckspd), .i_clk90(clk90),
    .o_ckstb(b_stb), .o_hlfck(b_hlf), .o_ckwide(b_w), .o_ckspd(b_spd), .o_clk90(b_c90)
  );

  sd_ckgen #(.OPT_SERDES(1'b1), .OPT_DDR(1'b0)) u_ser (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_ckspd(ckspd), .i_clk90(clk90),
    .o_ckstb(s_stb), .o_hlfck(s_hlf), .o_ckwide(s_w), .o_ckspd(s_spd), .o_clk90(s_c90)
  );

  sd_ckgen #(.OPT_SERDES(1'b0), .OPT_DDR(1'b1)) u_ddr (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_ckspd(ckspd), .i_clk90(clk90),
    .o_ckstb(d_stb), .o_hlfck(d_hlf), .o_ckwide(d_w), .o_ckspd(d_spd), .o_clk90(d_c90)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {hlfck, ckstb, ckwide} packed into one value per comparison
  function automatic int pk(input logic h, input logic s, input logic [7:0] w);
    return int'({h, s, w});
  endfunction

  initial begin
    en = 1'b1;
    ckspd = 8'd4;
    clk90 = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_out", pk(b_hlf, b_stb, b_w), pk(0, 0, 8'h00));
    chk("rst_spd", b_spd, 8'hff);
    chk("rst_c90", b_c90, 0);
    tick();
    chk("rst_hold", pk(b_hlf, b_stb, b_w), pk(0, 0, 8'h00));
    rst = 1'b0;

    // speed 4: H=3, period 6, hlfck first
    tick();
    chk("spd4_cfg", b_spd, 4);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      chk($sformatf("spd4_c%0d", i), pk(b_hlf, b_stb, b_w),
          pk(i % 6 == 0, i % 6 == 3, (i % 6 < 3) ? 8'hff : 8'h00));
    end
    en = 1'b0;
    repeat (8) tick();
    chk("idle_a", pk(b_hlf, b_stb, b_w), pk(0, 0, 8'h00));

    // request speed 0 with clk90 on all three builds
    ckspd = 8'd0;
    clk90 = 1'b1;
    en = 1'b1;
    tick();
    chk("ser_spd", s_spd, 0);
    chk("ser_c90", s_c90, 1);
    chk("ddr_spd", d_spd, 1);
    chk("ddr_c90", d_c90, 0);
    chk("base_spd", b_spd, 2);
    chk("base_c90", b_c90, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk($sformatf("ser0_c%0d", i), pk(s_hlf, s_stb, s_w), pk(1, 1, 8'h66));
      chk($sformatf("ddr1_c%0d", i), pk(d_hlf, d_stb, d_w), pk(1, 1, 8'h0f));
      chk($sformatf("base2_c%0d", i), pk(b_hlf, b_stb, b_w),
          pk(i % 2 == 0, i % 2 == 1, (i % 2 == 0) ? 8'hff : 8'h00));
    end
    clk90 = 1'b0;
    tick();
    chk("ser0_noc90_a", pk(s_hlf, s_stb, s_w), pk(1, 1, 8'h33));
    chk("ser0_c90_off", s_c90, 0);
    tick();
    chk("ser0_noc90_b", pk(s_hlf, s_stb, s_w), pk(1, 1, 8'h33));
    en = 1'b0;
    repeat (8) tick();
    chk("idle_b", pk(d_hlf, d_stb, d_w), pk(0, 0, 8'h00));

    // DDR speed 2 with clk90: f0 on hlfck, 0f on ckstb
    ckspd = 8'd2;
    clk90 = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("ddr2_c%0d", i), pk(d_hlf, d_stb, d_w),
          pk(i % 2 == 0, i % 2 == 1, (i % 2 == 0) ? 8'hf0 : 8'h0f));
      chk($sformatf("ddr2_both_c%0d", i), d_hlf & d_stb, 0);
    end
    chk("ddr2_c90", d_c90, 1);
    en = 1'b0;
    repeat (8) tick();

    // speed 10, enable dropped two cycles after hlfck
    ckspd = 8'd10;
    clk90 = 1'b0;
    en = 1'b1;
    tick();
    chk("stop_rise", pk(b_hlf, b_stb, b_w), pk(1, 0, 8'hff));
    tick();
    chk("stop_hi1", pk(b_hlf, b_stb, b_w), pk(0, 0, 8'hff));
    tick();
    chk("stop_hi2", pk(b_hlf, b_stb, b_w), pk(0, 0, 8'hff));
    en = 1'b0;
    for (int i = 3; i < 9; i++) begin
      tick();
      chk($sformatf("stop_hi%0d", i), pk(b_hlf, b_stb, b_w), pk(0, 0, 8'hff));
    end
    tick();
    chk("stop_fall", pk(b_hlf, b_stb, b_w), pk(0, 1, 8'h00));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stop_idle%0d", i), pk(b_hlf, b_stb, b_w), pk(0, 0, 8'h00));
    end

    // speed 3 -> 200 requested mid high half
    ckspd = 8'd3;
    en = 1'b1;
    tick();
    chk("chg_rise", pk(b_hlf, b_stb, b_w), pk(1, 0, 8'hff));
    ckspd = 8'd200;
    tick();
    chk("chg_hi", pk(b_hlf, b_stb, b_w), pk(0, 0, 8'hff));
    chk("chg_oldspd", b_spd, 3);
    tick();
    chk("chg_fall", pk(b_hlf, b_stb, b_w), pk(0, 1, 8'h00));
    chk("chg_spd_at_fall", b_spd, 3);
    for (int i = 0; i < 198; i++) begin
      tick();
      chk($sformatf("chg_lo%0d", i), pk(b_hlf, b_stb, b_w), pk(0, 0, 8'h00));
    end
    chk("chg_newspd", b_spd, 200);
    tick();
    chk("chg_rise2", pk(b_hlf, b_stb, b_w), pk(1, 0, 8'hff));
    for (int i = 0; i < 198; i++) begin
      tick();
      chk($sformatf("chg_hi%0d", i), pk(b_hlf, b_stb, b_w), pk(0, 0, 8'hff));
    end
    tick();
    chk("chg_fall2", pk(b_hlf, b_stb, b_w), pk(0, 1, 8'h00));
    repeat (5) tick();
    chk("pre_rst_spd", b_spd, 200);

    // async reset mid low half
    rst = 1'b1;
    #1;
    chk("arst_out", pk(b_hlf, b_stb, b_w), pk(0, 0, 8'h00));
    chk("arst_spd", b_spd, 8'hff);
    chk("arst_c90", b_c90, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_rise", pk(b_hlf, b_stb, b_w), pk(1, 0, 8'hff));
    chk("post_rst_spd", b_spd, 200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
